bsk_led_scheduler: RTL and testbench
====================================

// Module: bsk_led_scheduler
// PURPOSE
//  Time-shares the single 16-bit LED data bus among NUM_GRP LED latch groups (transmitter, receiver, alarm).
//  Runs round-robin slots. In each slot it drives one group's snapshot on oLed, then strobes that group's latch enable.
//  Sits between the command/status logic that produces per-group LED words and the external LED latches.
//  Adds group masking, a lamp-test override and a frame marker.
// PARAMETERS
//  WIDTH       16  LED word width per group
//  NUM_GRP     3   number of latch groups (>=1)
//  SETUP_CYC   1   cycles data is driven before LE rises (>=1)
//  STROBE_CYC  8   cycles LE is held high (>=1)
//  HOLD_CYC    1   cycles data is held after LE falls (>=1)
// PORTS
//  clk        in   1              system clock, all logic on rising edge
//  iReset     in   1              synchronous reset, active high
//  iEn        in   1              scheduler enable
//  iGrpMask   in   NUM_GRP        1 = group takes part in rotation
//  iLedData   in   NUM_GRP*WIDTH  group g word at [g*WIDTH +: WIDTH]
//  iLampTest  in   1              1 = all groups show all-ones
//  oLed       out  WIDTH          shared LED data bus
//  oLe        out  NUM_GRP        latch enables, at most one high (one-hot or zero)
//  oSlot      out  $clog2(NUM_GRP) (min 1)  index of group in current/last slot
//  oBusy      out  1              1 while a slot is in progress
//  oFrame     out  1              1-cycle pulse when rotation wraps
// BEHAVIOUR
//  - Reset: state IDLE; oLed=0, oLe=0, oSlot=0, oBusy=0, oFrame=0; round-robin pointer=0. Reset mid-slot aborts the slot.
//    oLe is 0 the cycle after reset is sampled.
//  - FSM states: IDLE, SETUP, STROBE, HOLD. One down-counter, width $clog2(max(*_CYC)+1), reloaded on every state entry.
//  - Group selection (sel): the first enabled group at or after the pointer, searching upward with wrap.
//    If no group is enabled (iGrpMask=0), no group is selected.
//  - IDLE -> SETUP: when iEn=1 and a group is selected. Otherwise stay in IDLE with oBusy=0.
//    Latency: iEn sampled high at edge N -> oBusy=1 and new oLed at N+1.
//  - On each SETUP entry, register the snapshot:
//    oLed <= iLampTest ? all-ones : iLedData[sel]; oSlot <= sel; pointer <= sel+1 mod NUM_GRP.
//  - oLed and oSlot stay constant for the whole slot (SETUP+STROBE+HOLD).
//    iLedData / iLampTest changes take effect only at the next SETUP entry.
//  - SETUP: oLe=0 for SETUP_CYC cycles, then go to STROBE.
//  - STROBE: oLe[oSlot]=1 for STROBE_CYC cycles, then go to HOLD.
//  - HOLD: oLe=0 for HOLD_CYC cycles. Then:
//    - if iEn=1 and a group is selected: go to SETUP for the next group (no idle gap);
//    - otherwise go to IDLE, with oLed/oSlot holding their last values.
//  - Slot length = SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (10 with the defaults).
//  - iEn=0 or a mask change mid-slot never truncates the current slot. Both are evaluated only at the end of HOLD.
//  - A masked group is skipped. A mask change re-evaluates sel at the next slot start.
//  - oFrame: 1 for the first cycle of a SETUP whose sel <= the previous slot's oSlot (rotation wrapped).
//    This includes every slot when only one group is enabled. It is not asserted on the first slot after IDLE.
//  - oLe is never high in SETUP, HOLD or IDLE. Two oLe bits are never high together.
// TESTING
//  1. Reset, mask=3'b011, g0=AAAA, g1=5555, iEn=1:
//     cycles 1-10 oLed=AAAA with oLe[0]=1 in cycles 2-9; cycles 11-20 oLed=5555 with oLe[1]=1 in cycles 12-19;
//     oFrame=1 at cycle 21.
//  2. Change g0 to 1234 during the g0 STROBE -> oLed stays AAAA until the next g0 slot, which shows 1234.
//  3. mask=3'b101 -> slot order 0,2,0,2. oLe[1] is never 1. oFrame fires at each return to group 0.
//  4. Assert iLampTest during a slot -> the current slot is unchanged; the next slot shows oLed=FFFF.
//     Deassert -> the following slot shows real data.
//  5. iEn=0 during STROBE -> the slot finishes its full 10 cycles, then IDLE with oBusy=0, oLe=0 and oLed held.
//     iReset=1 during STROBE -> next cycle oLe=0, oLed=0.
//  6. mask=0 with iEn=1 -> stays IDLE, oBusy=0, oLe=0 indefinitely. Setting mask=3'b100 -> next cycle SETUP with oSlot=2.

Source files
------------

// File: rtl/bsk_led_scheduler.sv
// Round-robin scheduler that time-shares one LED data bus across several latch groups.
// Each slot drives a registered snapshot, pulses that group's latch enable, then holds the data.
module bsk_led_scheduler #(
  parameter int WIDTH      = 16,
  parameter int NUM_GRP    = 3,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 1,
  localparam int SW        = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
  input  logic                     clk,
  input  logic                     iReset,
  input  logic                     iEn,
  input  logic [NUM_GRP-1:0]       iGrpMask,
  input  logic [NUM_GRP*WIDTH-1:0] iLedData,
  input  logic                     iLampTest,
  output logic [WIDTH-1:0]         oLed,
  output logic [NUM_GRP-1:0]       oLe,
  output logic [SW-1:0]            oSlot,
  output logic                     oBusy,
  output logic                     oFrame
);

  localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [NUM_GRP-1:0] LE_ONE = NUM_GRP'(1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic [SW-1:0]      ptr_r;
  logic [WIDTH-1:0]   led_r;
  logic [NUM_GRP-1:0] le_r;
  logic [SW-1:0]      slot_r;
  logic               busy_r;
  logic               frame_r;

  logic [SW-1:0]      sel_s;
  logic               sel_ok_s;
  logic [SW-1:0]      next_ptr_s;
  logic [WIDTH-1:0]   snap_s;
  logic               slot_end_s;
  logic               start_s;
  logic               frame_s;

  // Returns {found, index} of the first enabled group at or after ptr, wrapping to the lowest one.
  function automatic logic [SW:0] find_sel(input logic [NUM_GRP-1:0] mask,
                                           input logic [SW-1:0] ptr);
    logic [NUM_GRP-1:0] m;
    logic               any_hit;
    logic               up_hit;
    logic [SW-1:0]      any_idx;
    logic [SW-1:0]      up_idx;
    m       = mask;
    any_hit = 1'b0;
    up_hit  = 1'b0;
    any_idx = '0;
    up_idx  = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      if (m[0] && !any_hit) begin
        any_hit = 1'b1;
        any_idx = SW'(g);
      end
      if (m[0] && !up_hit && (g >= int'(ptr))) begin
        up_hit = 1'b1;
        up_idx = SW'(g);
      end
      m = m >> 1;
    end
    return up_hit ? {1'b1, up_idx} : {any_hit, any_idx};
  endfunction

  // Next-group selection, snapshot and slot-start decision.
  always_comb begin
    {sel_ok_s, sel_s} = find_sel(iGrpMask, ptr_r);
    snap_s = iLampTest ? {WIDTH{1'b1}} : WIDTH'(iLedData >> (int'(sel_s) * WIDTH));
    if (sel_s == SW'(NUM_GRP - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = sel_s + SW'(1);
    end
    slot_end_s = (state_r == HOLD) && (cnt_r == '0);
    start_s    = iEn && sel_ok_s && ((state_r == IDLE) || slot_end_s);
    // Back-to-back slots only: a slot started from IDLE never marks a frame.
    frame_s    = slot_end_s && (sel_s <= slot_r);
  end

  // Slot sequencer with registered bus, strobe and status outputs.
  always_ff @(posedge clk) begin
    if (iReset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      ptr_r   <= '0;
      led_r   <= '0;
      le_r    <= '0;
      slot_r  <= '0;
      busy_r  <= 1'b0;
      frame_r <= 1'b0;
    end else if (start_s) begin
      state_r <= SETUP;
      cnt_r   <= CW'(SETUP_CYC - 1);
      led_r   <= snap_s;
      slot_r  <= sel_s;
      ptr_r   <= next_ptr_s;
      busy_r  <= 1'b1;
      le_r    <= '0;
      frame_r <= frame_s;
    end else begin
      frame_r <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_r <= 1'b0;
          le_r   <= '0;
        end
        SETUP: begin
          if (cnt_r == '0) begin
            state_r <= STROBE;
            cnt_r   <= CW'(STROBE_CYC - 1);
            le_r    <= LE_ONE << slot_r;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        STROBE: begin
          if (cnt_r == '0) begin
            state_r <= HOLD;
            cnt_r   <= CW'(HOLD_CYC - 1);
            le_r    <= '0;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        HOLD: begin
          if (cnt_r == '0) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            le_r    <= '0;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          busy_r  <= 1'b0;
          le_r    <= '0;
        end
      endcase
    end
  end

  assign oLed   = led_r;
  assign oLe    = le_r;
  assign oSlot  = slot_r;
  assign oBusy  = busy_r;
  assign oFrame = frame_r;

endmodule

// File: tb/tb_bsk_led_scheduler.sv
// Directed bench for bsk_led_scheduler: expected slots are queued by the stimulus
// and checked by an independent monitor at each strobe start.
module tb_bsk_led_scheduler;

  logic        clk = 1'b0;
  logic        iReset;
  logic        iEn;
  logic [2:0]  iGrpMask;
  logic [47:0] iLedData;
  logic        iLampTest;
  logic [15:0] oLed;
  logic [2:0]  oLe;
  logic [1:0]  oSlot;
  logic        oBusy;
  logic        oFrame;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  slot;
    logic [15:0] led;
    logic        frame;
  } exp_t;

  exp_t sb_q[$];

  bsk_led_scheduler dut (
    .clk      (clk),
    .iReset   (iReset),
    .iEn      (iEn),
    .iGrpMask (iGrpMask),
    .iLedData (iLedData),
    .iLampTest(iLampTest),
    .oLed     (oLed),
    .oLe      (oLe),
    .oSlot    (oSlot),
    .oBusy    (oBusy),
    .oFrame   (oFrame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] s, input logic [15:0] d, input logic f);
    exp_t e;
    e.slot  = s;
    e.led   = d;
    e.frame = f;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pops one expected slot at every strobe start, checks strobe length and oLe sanity.
  initial begin
    logic [2:0] prev_le;
    int         le_len;
    logic       frame_seen;
    exp_t       e;
    prev_le    = 3'b000;
    le_len     = 0;
    frame_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (iReset) begin
        prev_le    = 3'b000;
        le_len     = 0;
        frame_seen = 1'b0;
      end else begin
        chk("le_onehot0", 32'($countones(oLe) <= 1), 32'd1);
        chk("le_only_busy", 32'((oLe != 3'b000) && !oBusy), 32'd0);
        if (oFrame) frame_seen = 1'b1;
        if ((oLe != 3'b000) && (prev_le == 3'b000)) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: strobe for slot %0d with no expected entry", oSlot);
          end else begin
            e = sb_q.pop_front();
            chk("sb_le", 32'(oLe), 32'(3'b001 << e.slot));
            chk("sb_led", 32'(oLed), 32'(e.led));
            chk("sb_slot", 32'(oSlot), 32'(e.slot));
            chk("sb_frame", 32'(frame_seen), 32'(e.frame));
          end
          frame_seen = 1'b0;
        end
        if (oLe != 3'b000) begin
          le_len++;
        end else if (prev_le != 3'b000) begin
          chk("strobe_len", 32'(le_len), 32'd8);
          le_len = 0;
        end
        prev_le = oLe;
      end
    end
  end

  // Directed stimulus; cycle numbers count negedges after the first enable.
  initial begin
    iReset    = 1'b1;
    iEn       = 1'b0;
    iGrpMask  = 3'b000;
    iLampTest = 1'b0;
    iLedData  = {16'h0F0F, 16'h5555, 16'hAAAA};
    step(2);
    chk("rst_led", 32'(oLed), 32'd0);
    chk("rst_le", 32'(oLe), 32'd0);
    chk("rst_slot", 32'(oSlot), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_frame", 32'(oFrame), 32'd0);

    iReset   = 1'b0;
    iEn      = 1'b1;
    iGrpMask = 3'b011;
    push(2'd0, 16'hAAAA, 1'b0);
    push(2'd1, 16'h5555, 1'b0);
    push(2'd0, 16'h1234, 1'b1);
    step(1);
    chk("c1_led", 32'(oLed), 32'h0000AAAA);
    chk("c1_le", 32'(oLe), 32'd0);
    chk("c1_busy", 32'(oBusy), 32'd1);
    step(1);
    chk("c2_le", 32'(oLe), 32'd1);
    step(1);
    iLedData[15:0] = 16'h1234;
    step(2);
    chk("c5_led_held", 32'(oLed), 32'h0000AAAA);
    step(4);
    chk("c9_le", 32'(oLe), 32'd1);
    step(1);
    chk("c10_le", 32'(oLe), 32'd0);
    chk("c10_led", 32'(oLed), 32'h0000AAAA);
    step(1);
    chk("c11_led", 32'(oLed), 32'h00005555);
    chk("c11_slot", 32'(oSlot), 32'd1);
    chk("c11_frame", 32'(oFrame), 32'd0);
    step(1);
    chk("c12_le", 32'(oLe), 32'd2);
    step(9);
    chk("c21_frame", 32'(oFrame), 32'd1);
    chk("c21_led", 32'(oLed), 32'h00001234);
    chk("c21_slot", 32'(oSlot), 32'd0);
    step(1);
    chk("c22_frame", 32'(oFrame), 32'd0);

    iGrpMask = 3'b101;
    push(2'd2, 16'h0F0F, 1'b0);
    push(2'd0, 16'h1234, 1'b1);
    push(2'd2, 16'h0F0F, 1'b0);
    push(2'd0, 16'h1234, 1'b1);
    step(9);
    chk("c31_slot", 32'(oSlot), 32'd2);
    chk("c31_led", 32'(oLed), 32'h00000F0F);
    step(10);
    chk("c41_slot", 32'(oSlot), 32'd0);
    chk("c41_frame", 32'(oFrame), 32'd1);
    step(22);

    iLampTest = 1'b1;
    push(2'd2, 16'hFFFF, 1'b0);
    push(2'd0, 16'h1234, 1'b1);
    step(2);
    chk("c65_lamp_late", 32'(oLed), 32'h00001234);
    step(6);
    chk("c71_lamp_led", 32'(oLed), 32'h0000FFFF);
    chk("c71_slot", 32'(oSlot), 32'd2);
    step(2);
    iLampTest = 1'b0;
    step(8);
    chk("c81_led", 32'(oLed), 32'h00001234);
    step(2);

    iEn = 1'b0;
    step(7);
    chk("c90_busy", 32'(oBusy), 32'd1);
    step(1);
    chk("c91_busy", 32'(oBusy), 32'd0);
    chk("c91_le", 32'(oLe), 32'd0);
    chk("c91_led_held", 32'(oLed), 32'h00001234);
    chk("c91_slot_held", 32'(oSlot), 32'd0);
    step(4);
    chk("c95_busy", 32'(oBusy), 32'd0);
    iEn = 1'b1;
    push(2'd2, 16'h0F0F, 1'b0);
    step(1);
    chk("c96_busy", 32'(oBusy), 32'd1);
    chk("c96_slot", 32'(oSlot), 32'd2);
    chk("c96_frame", 32'(oFrame), 32'd0);
    step(3);
    chk("c99_le", 32'(oLe), 32'd4);
    iReset = 1'b1;
    step(1);
    chk("c100_le", 32'(oLe), 32'd0);
    chk("c100_led", 32'(oLed), 32'd0);
    chk("c100_busy", 32'(oBusy), 32'd0);
    step(2);

    iReset   = 1'b0;
    iGrpMask = 3'b000;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("nomask_busy", 32'(oBusy), 32'd0);
      chk("nomask_le", 32'(oLe), 32'd0);
    end
    iGrpMask = 3'b100;
    push(2'd2, 16'h0F0F, 1'b0);
    push(2'd2, 16'h0F0F, 1'b1);
    step(1);
    chk("c108_busy", 32'(oBusy), 32'd1);
    chk("c108_slot", 32'(oSlot), 32'd2);
    chk("c108_led", 32'(oLed), 32'h00000F0F);
    step(10);
    chk("c118_frame", 32'(oFrame), 32'd1);
    step(2);
    iEn = 1'b0;
    step(10);
    chk("c130_busy", 32'(oBusy), 32'd0);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
